// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and frame constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_e;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: assembles little-endian bytes into 32-bit words, pulsing word_valid_o on the last byte
module loader_word_pack
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [31:0] shift_q;

    // The completed word is presented combinationally so the caller can act on it in the same cycle
    assign word_o       = {byte_i, shift_q[31:8]};
    assign word_valid_o = byte_valid_i && cnt_q == 2'(WORD_BYTES - 1);

    // Byte counter and shift register; new bytes enter at the top so the first byte ends up in [7:0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= word_o;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream and writes it into the instruction ROM
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int   ADDR_W        = 12,
    parameter int   TIMEOUT_CYC   = 1000000,
    parameter logic HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_e              state_q;
    logic [ADDR_W:0]     n_q;
    logic [ADDR_W:0]     idx_q;
    logic [7:0]          csum_q;
    logic [TO_W-1:0]     idle_q;
    logic                rom_we_q;
    logic [ADDR_W-1:0]   rom_waddr_q;
    logic [31:0]         rom_wdata_q;
    logic                cpu_hold_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                start_ok;
    logic                pk_valid;
    logic                pk_word_valid;
    logic [31:0]         pk_word;
    logic [32:0]         n_raw;
    logic                len_bad;
    logic [ADDR_W:0]     idx_nx;
    logic                timeout;

    assign in_ready     = state_q inside {LEN, DATA, CSUM};
    assign accept       = in_valid && in_ready;
    assign start_ok     = start && state_q inside {IDLE, DONE, ERR};
    assign pk_valid     = accept && state_q inside {LEN, DATA};
    assign n_raw        = {1'b0, pk_word[LEN_BYTES*8-1:0]};
    assign len_bad      = n_raw == 33'd0 || n_raw > (33'd1 << ADDR_W);
    assign idx_nx       = idx_q + 1'b1;
    assign timeout      = in_ready && !accept && idle_q == TO_W'(TIMEOUT_CYC - 1);

    assign rom_we       = rom_we_q;
    assign rom_waddr    = rom_waddr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = idx_q;

    loader_word_pack u_pack (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .byte_valid_i (pk_valid),
        .byte_i       (in_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // Load sequencer: frame parsing, ROM write strobe, checksum, idle timeout and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            idle_q      <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            cpu_hold_q  <= HOLD_AT_RESET;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rom_we_q <= 1'b0;
            if (in_ready) idle_q <= accept ? '0 : idle_q + TO_W'(1);
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q    <= LEN;
                        idx_q      <= '0;
                        csum_q     <= '0;
                        idle_q     <= '0;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                LEN: begin
                    if (timeout) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (pk_word_valid) begin
                        n_q     <= pk_word[ADDR_W:0];
                        state_q <= len_bad ? ERR : DATA;
                        err_q   <= len_bad;
                    end
                end
                DATA: begin
                    if (timeout) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (accept) begin
                        csum_q <= csum_q ^ in_data;
                        if (pk_word_valid) begin
                            rom_we_q    <= 1'b1;
                            rom_waddr_q <= idx_q[ADDR_W-1:0];
                            rom_wdata_q <= pk_word;
                            idx_q       <= idx_nx;
                            if (idx_nx == n_q) state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (timeout) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (accept) begin
                        state_q    <= in_data == csum_q ? DONE : ERR;
                        cpu_hold_q <= in_data != csum_q;
                        done_q     <= in_data == csum_q;
                        err_q      <= in_data != csum_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for the program loader
module tb_prog_loader;

    localparam int AW = 12;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    int            wr_n = 0;
    logic [AW-1:0] wa [64];
    logic [31:0]   wd [64];
    logic [AW:0]   wl [64];

    logic [7:0] xr;
    int         b;

    prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .HOLD_AT_RESET(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rom_we       (rom_we),
        .rom_waddr    (rom_waddr),
        .rom_wdata    (rom_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Log every cycle rom_we is high, with the address, data and word count seen in that cycle
    always @(negedge clk) begin
        if (rom_we === 1'b1 && wr_n < 64) begin
            wa[wr_n] = rom_waddr;
            wd[wr_n] = rom_wdata;
            wl[wr_n] = words_loaded;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = v;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            check("ready_wait", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gm, input bit data);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] by;
            by = w[8*i +: 8];
            if (data) xr = xr ^ by;
            send_byte(by, gm == 0 ? 0 : int'($urandom_range(0, gm)));
        end
    endtask

    task automatic frame(input int gm, input bit bad);
        xr = 8'h00;
        send_word(32'd2, gm, 1'b0);
        send_word(32'h0000_0013, gm, 1'b1);
        send_word(32'hDEAD_BEEF, gm, 1'b1);
        send_byte(bad ? 8'h00 : xr, gm);
    endtask

    task automatic check_writes(input int base);
        check("wr_count", wr_n, base + 2);
        if (wr_n >= base + 2 && base + 2 <= 64) begin
            check("wr0_addr", wa[base], 0);
            check("wr0_data", wd[base], 32'h0000_0013);
            check("wr0_wl", wl[base], 1);
            check("wr1_addr", wa[base+1], 1);
            check("wr1_data", wd[base+1], 32'hDEAD_BEEF);
            check("wr1_wl", wl[base+1], 2);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_rom_we"}, rom_we, 0);
        check({tag, "_rom_waddr"}, rom_waddr, 0);
        check({tag, "_rom_wdata"}, rom_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        xr = 8'h00;
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Back-to-back good frame
        do_start();
        check("start_ready", in_ready, 1);
        check("start_hold", cpu_hold, 1);
        b = wr_n;
        frame(0, 1'b0);
        check("ok_done", done, 1);
        check("ok_err", err, 0);
        check("ok_hold", cpu_hold, 0);
        check("ok_words", words_loaded, 2);
        check("ok_ready", in_ready, 0);
        check_writes(b);

        // Restart from DONE, then a bad checksum
        do_start();
        check("restart_done", done, 0);
        check("restart_hold", cpu_hold, 1);
        check("restart_words", words_loaded, 0);
        b = wr_n;
        frame(0, 1'b1);
        check("bad_err", err, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        check_writes(b);

        // Illegal lengths
        do_start();
        b = wr_n;
        send_word(32'd0, 0, 1'b0);
        check("n0_err", err, 1);
        check("n0_ready", in_ready, 0);
        do_start();
        check("n4097_clear", err, 0);
        send_word(32'd4097, 0, 1'b0);
        check("n4097_err", err, 1);
        check("n4097_ready", in_ready, 0);
        repeat (3) tick();
        check("nlen_no_write", wr_n, b);

        // Random gaps below the timeout
        do_start();
        b = wr_n;
        frame(TO - 1, 1'b0);
        check("gap_done", done, 1);
        check("gap_err", err, 0);
        check("gap_words", words_loaded, 2);
        check_writes(b);

        // Idle gap reaching the timeout inside DATA
        do_start();
        xr = 8'h00;
        send_word(32'd2, 0, 1'b0);
        send_word(32'h0000_0013, 0, 1'b1);
        repeat (TO - 1) tick();
        check("to_before_err", err, 0);
        check("to_before_ready", in_ready, 1);
        tick();
        check("to_err", err, 1);
        check("to_ready", in_ready, 0);
        check("to_hold", cpu_hold, 1);

        // Asynchronous reset after 5 DATA bytes, then a clean reload
        do_start();
        xr = 8'h00;
        send_word(32'd2, 0, 1'b0);
        send_word(32'h0000_0013, 0, 1'b1);
        send_byte(8'hEF, 0);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h02;
        do_start();
        b = wr_n;
        frame(0, 1'b0);
        check("reload_done", done, 1);
        check("reload_hold", cpu_hold, 0);
        check_writes(b);

        // start during DATA is ignored
        do_start();
        b = wr_n;
        xr = 8'h00;
        send_word(32'd2, 0, 1'b0);
        send_word(32'h0000_0013, 0, 1'b1);
        do_start();
        send_word(32'hDEAD_BEEF, 0, 1'b1);
        send_byte(xr, 0);
        check("midstart_done", done, 1);
        check("midstart_words", words_loaded, 2);
        check_writes(b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
